fifo_flags: RTL and testbench

Parametrised synchronous FIFO for the receiver datapath. It is the next-generation replacement for the basic 2**N-1-entry FIFO: all 2**SIZE_POW2 entries are usable, and it adds an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It also adds a synchronous flush and a selectable first-word-fall-through (FWFT) read mode. It sits between sample-producing stages and slower consumers, for example between the demodulator output and the packet parser.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_mem.sv | 20 ++
 rtl/fifo_flags.sv | 92 +++++++++
 tb/tb_fifo_flags.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared read-mode type, depth helper and parameter legality check for fifo_flags
package fifo_pkg;
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } rd_mode_e;
  function automatic int depth(input int size_pow2);
    return 1 << size_pow2;
  endfunction
  function automatic bit params_ok(input int size_pow2, input int af, input int ae, input int fwft);
    return size_pow2 >= 1 && size_pow2 <= 12 &&
           af >= 1 && af <= depth(size_pow2) &&
           ae >= 0 && ae <= depth(size_pow2) - 1 &&
           (fwft == 0 || fwft == 1);
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DW storage, synchronous write port, asynchronous read address
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [depth(AW)];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_flags.sv
// fifo_flags: full-depth synchronous FIFO with occupancy count, threshold flags, sticky errors, flush and FWFT mode
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int DW        = 8,
  parameter int SIZE_POW2 = 4,
  parameter int AF_THRESH = depth(SIZE_POW2) - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 wr_en_i,
  input  logic [DW-1:0]        wr_data_i,
  input  logic                 rd_en_i,
  output logic [DW-1:0]        rd_data_o,
  output logic                 rd_valid_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [SIZE_POW2:0]   count_o,
  output logic                 overflow_o,
  output logic                 underflow_o,
  input  logic                 err_clr_i
);
  localparam int PW = SIZE_POW2 + 1;
  localparam rd_mode_e MODE = FWFT == 1 ? FIFO_FWFT : FIFO_STD;
  localparam logic [PW-1:0] AF_L = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_L = PW'(AE_THRESH);
  if (!params_ok(SIZE_POW2, AF_THRESH, AE_THRESH, FWFT)) begin : g_bad_params
    $error("fifo_flags: illegal parameter combination");
  end
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [DW-1:0] rd_data_q, rd_data_d, mem_rdata;
  logic          rd_valid_q, rd_valid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic          wr_acc, rd_acc, full, empty;
  // Extra pointer MSB distinguishes full from empty so every entry is usable
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full  = (wr_ptr_q[SIZE_POW2] != rd_ptr_q[SIZE_POW2]) &&
                 (wr_ptr_q[SIZE_POW2-1:0] == rd_ptr_q[SIZE_POW2-1:0]);
  always_comb begin
    wr_acc     = wr_en_i && !full && !flush_i;
    rd_acc     = rd_en_i && !empty && !flush_i;
    wr_ptr_d   = flush_i ? '0 : wr_ptr_q + PW'(wr_acc);
    rd_ptr_d   = flush_i ? '0 : rd_ptr_q + PW'(rd_acc);
    count_d    = flush_i ? '0 : count_q + PW'(wr_acc) - PW'(rd_acc);
    rd_data_d  = rd_acc ? mem_rdata : rd_data_q;
    rd_valid_d = rd_acc;
    // Set beats clear when both happen in one cycle
    ovf_d      = (wr_en_i && full && !flush_i) || (ovf_q && !err_clr_i);
    udf_d      = (rd_en_i && empty && !flush_i) || (udf_q && !err_clr_i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end
  fifo_mem #(.DW(DW), .AW(SIZE_POW2)) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[SIZE_POW2-1:0]),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q[SIZE_POW2-1:0]),
    .rdata_o (mem_rdata)
  );
  // In FWFT mode the head entry is shown directly; when empty the last popped word is held
  assign rd_data_o      = (MODE == FIFO_FWFT && !empty) ? mem_rdata : rd_data_q;
  assign rd_valid_o     = (MODE == FIFO_FWFT) ? !empty : rd_valid_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = count_q >= AF_L;
  assign almost_empty_o = count_q <= AE_L;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;
endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: randomized scoreboard bench for fifo_flags in registered and FWFT read modes
module tb_fifo_flags;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush, wr_en, rd_en, err_clr;
  logic [7:0] wr_data;
  logic [7:0] rd0, rd1;
  logic rv0, rv1, full0, full1, empty0, empty1, af0, af1, ae0, ae1, ovf0, ovf1, udf0, udf1;
  logic [4:0] cnt0, cnt1;
  always #5 clk = ~clk;
  fifo_flags #(.DW(8), .SIZE_POW2(4), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_data_o(rd0), .rd_valid_o(rv0), .full_o(full0), .empty_o(empty0),
    .almost_full_o(af0), .almost_empty_o(ae0), .count_o(cnt0), .overflow_o(ovf0),
    .underflow_o(udf0), .err_clr_i(err_clr));
  fifo_flags #(.DW(8), .SIZE_POW2(4), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_data_o(rd1), .rd_valid_o(rv1), .full_o(full1), .empty_o(empty1),
    .almost_full_o(af1), .almost_empty_o(ae1), .count_o(cnt1), .overflow_o(ovf1),
    .underflow_o(udf1), .err_clr_i(err_clr));
  logic [7:0] q[$];
  logic [7:0] sb[$];
  bit m_ovf, m_udf, exp_v0, mon_en;
  int checks = 0, failures = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input bit wr, input logic [7:0] wd, input bit rd, input bit fl = 0, input bit ec = 0);
    bit full_m, empty_m, wacc, racc;
    wr_en = wr; wr_data = wd; rd_en = rd; flush = fl; err_clr = ec;
    full_m  = q.size() == DEPTH;
    empty_m = q.size() == 0;
    wacc = wr && !full_m && !fl;
    racc = rd && !empty_m && !fl;
    @(posedge clk); #1;
    if (fl) q.delete();
    else begin
      if (racc) sb.push_back(q.pop_front());
      if (wacc) q.push_back(wd);
    end
    m_ovf  = (wr && full_m && !fl) ? 1'b1 : (ec ? 1'b0 : m_ovf);
    m_udf  = (rd && empty_m && !fl) ? 1'b1 : (ec ? 1'b0 : m_udf);
    exp_v0 = racc;
  endtask
  task automatic chk_reset_outputs();
    chk("rst_count0", cnt0, 0);   chk("rst_count1", cnt1, 0);
    chk("rst_empty0", empty0, 1); chk("rst_empty1", empty1, 1);
    chk("rst_ae0", ae0, 1);       chk("rst_full0", full0, 0);
    chk("rst_af0", af0, 0);       chk("rst_valid0", rv0, 0);
    chk("rst_valid1", rv1, 0);    chk("rst_data0", rd0, 0);
    chk("rst_data1", rd1, 0);     chk("rst_ovf0", ovf0, 0);
    chk("rst_udf0", udf0, 0);     chk("rst_ovf1", ovf1, 0);
  endtask
  task automatic async_reset();
    wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    q.delete(); sb.delete();
    m_ovf = 0; m_udf = 0; exp_v0 = 0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count0", cnt0, q.size());
      chk("count1", cnt1, q.size());
      chk("empty0", empty0, q.size() == 0);
      chk("empty1", empty1, q.size() == 0);
      chk("full0", full0, q.size() == DEPTH);
      chk("full1", full1, q.size() == DEPTH);
      chk("almost_full0", af0, q.size() >= DEPTH - 2);
      chk("almost_empty0", ae0, q.size() <= 2);
      chk("almost_full1", af1, q.size() >= DEPTH - 2);
      chk("almost_empty1", ae1, q.size() <= 2);
      chk("overflow0", ovf0, m_ovf);
      chk("underflow0", udf0, m_udf);
      chk("overflow1", ovf1, m_ovf);
      chk("underflow1", udf1, m_udf);
      chk("valid0", rv0, exp_v0);
      if (rv0) begin
        if (sb.size() == 0) chk("sb_unexpected0", 1, 0);
        else chk("data0", rd0, sb.pop_front());
      end
      chk("valid1", rv1, q.size() > 0);
      if (q.size() > 0) chk("data1", rd1, q[0]);
    end
  end
  initial begin
    wr_en = 0; rd_en = 0; flush = 0; err_clr = 0; wr_data = 0;
    m_ovf = 0; m_udf = 0; exp_v0 = 0; mon_en = 0;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs();
    mon_en = 1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'hFF, 0);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0);
    for (int i = 0; i < 8; i++) cyc(1, 8'($urandom), 0);
    for (int i = 0; i < 40; i++) cyc(1, 8'($urandom), 1);
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    cyc(1, 8'hA5, 0);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h50 + i), 0);
    cyc(1, 8'h77, 0, 1);
    cyc(0, 8'h00, 0);
    for (int i = 0; i < 9; i++) cyc(1, 8'(8'h90 + i), 0);
    async_reset();
    cyc(1, 8'h3C, 0);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    for (int p = 0; p < 8; p++) begin
      int pw;
      pw = $urandom_range(20, 80);
      for (int i = 0; i < 50; i++)
        cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) >= pw,
            $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 20; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    @(posedge clk); #1;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
